// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared types and constants for the NCO sweep sequencer
//
// Contents:
//   NCO_DEF_STEP  : step word the NCO and the step mirror load on NCO reset
//   nco_word_t    : signed 16-bit frequency-rate / phase-offset word
//   sweep_state_t : sequencer state encoding
//   step_add      : 16-bit wrapping step update

package nco_pkg;

  // Single source for the NCO reset step (40 kHz). The NCO's own reset
  // value and the controller's step mirror both use it.
  localparam logic [15:0] NCO_DEF_STEP = 16'd13107;

  typedef logic signed [15:0] nco_word_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NCO_RST = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SWEEP   = 3'd3,
    ST_DWELL   = 3'd4,
    ST_DONE    = 3'd5
  } sweep_state_t;

  // The NCO accumulates its step modulo 2^16; the mirror must wrap the
  // same way, so the signed rate is added as a raw bit pattern.
  function automatic logic [15:0] step_add(input logic [15:0] step,
                                           input nco_word_t   rate);
    return step + $unsigned(rate);
  endfunction

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// rtl/nco_sweep_ctrl_if.sv - host/config and NCO-side signals of the sweep sequencer
//
// Host side : start_i, abort_i, rate_i, nticks_i, dwell_i, ofst_i (to sequencer)
//             busy_o, done_o, step_o                         (from sequencer)
// NCO side  : tick_o, nco_rst_o, freq_o, ofst_o              (from sequencer)
// Modports  : master = host/bench, slave = nco_sweep_ctrl

interface nco_sweep_ctrl_if;

  logic                start_i;
  logic                abort_i;
  nco_pkg::nco_word_t  rate_i;
  logic [15:0]         nticks_i;
  logic [15:0]         dwell_i;
  nco_pkg::nco_word_t  ofst_i;

  logic                tick_o;
  logic                nco_rst_o;
  nco_pkg::nco_word_t  freq_o;
  nco_pkg::nco_word_t  ofst_o;
  logic [15:0]         step_o;
  logic                busy_o;
  logic                done_o;

  modport master (
    output start_i, abort_i, rate_i, nticks_i, dwell_i, ofst_i,
    input  tick_o, nco_rst_o, freq_o, ofst_o, step_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, rate_i, nticks_i, dwell_i, ofst_i,
    output tick_o, nco_rst_o, freq_o, ofst_o, step_o, busy_o, done_o
  );

endinterface

// File: rtl/nco_sweep_ctrl_tick_divider.sv
// rtl/nco_sweep_ctrl_tick_divider.sv - free-running sample-tick divider with synchronous clear
//
// Ports:
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset (count -> 0)
//   clr_i  : synchronous clear; also masks tick_o in the same cycle
//   tick_o : one-cycle strobe when count == CLK_DIV-1

module tick_divider #(
  parameter int CLK_DIV = 250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Masking with clr_i keeps the NCO-reset cycle tick-free even when the
  // clear lands on a count that would otherwise have fired.
  assign tick_o = (cnt_q == LAST) && !clr_i;

endmodule

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - NCO channel sequencer: sample strobe plus reset/settle/sweep/dwell chirp
//
// Ports:
//   clk_i : system clock
//   rst_i : synchronous active-high reset
//   bus   : nco_sweep_ctrl_if.slave
//             start_i/abort_i      run control (start sampled in IDLE only)
//             rate_i/ofst_i        per-tick step increment / one-shot phase offset
//             nticks_i/dwell_i     sweep and dwell lengths in ticks
//             tick_o/nco_rst_o     NCO sample strobe / NCO reset pulse
//             freq_o/ofst_o        NCO frequency-rate / phase-offset drive
//             step_o               mirror of the NCO step word
//             busy_o/done_o        not-IDLE flag / one-cycle completion pulse

module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int          CLK_DIV      = 250,
  parameter logic [15:0] DEF_STEP     = NCO_DEF_STEP,
  parameter int          SETTLE_TICKS = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  nco_sweep_ctrl_if.slave bus
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_TICKS - 1);

  sweep_state_t state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         load_cfg;

  // Configuration latched at start so host-side changes mid-run are inert.
  nco_word_t    rate_q;
  nco_word_t    ofst_q;
  logic [15:0]  nticks_q;
  logic [15:0]  dwell_q;

  logic         tick;
  logic         div_clr;
  nco_word_t    freq;
  nco_word_t    ofst;
  logic [15:0]  step_q;

  // Restarting the divider at NCO reset aligns the first settle tick to a
  // full CLK_DIV period after the NCO comes out of reset.
  assign div_clr = (state_q == ST_NCO_RST);

  tick_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_divider (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (div_clr),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rate_q   <= '0;
      ofst_q   <= '0;
      nticks_q <= '0;
      dwell_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_cfg) begin
        rate_q   <= bus.rate_i;
        ofst_q   <= bus.ofst_i;
        nticks_q <= bus.nticks_i;
        dwell_q  <= bus.dwell_i;
      end
    end
  end

  // cnt_q counts ticks within the current state and restarts at 0 on every
  // state change, so the sweep's first tick is the one with cnt_q == 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_cfg = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.start_i && !bus.abort_i) begin
          load_cfg = 1'b1;
          state_d  = ST_NCO_RST;
        end
      end

      ST_NCO_RST: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (tick) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d = '0;
            if (nticks_q != 16'd0) begin
              state_d = ST_SWEEP;
            end else if (dwell_q != 16'd0) begin
              state_d = ST_DWELL;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      ST_SWEEP: begin
        if (tick) begin
          if (cnt_q == nticks_q - 16'd1) begin
            cnt_d   = '0;
            state_d = (dwell_q != 16'd0) ? ST_DWELL : ST_DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      ST_DWELL: begin
        if (tick) begin
          if (cnt_q == dwell_q - 16'd1) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (bus.abort_i && (state_q != ST_IDLE)) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
    end
  end

  // Decoded from registered state only, so both are settled before any tick.
  assign freq = (state_q == ST_SWEEP) ? rate_q : '0;
  assign ofst = ((state_q == ST_SWEEP) && (cnt_q == 16'd0)) ? ofst_q : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_q <= DEF_STEP;
    end else if (div_clr) begin
      step_q <= DEF_STEP;
    end else if (tick) begin
      step_q <= step_add(step_q, freq);
    end
  end

  assign bus.tick_o    = tick;
  assign bus.nco_rst_o = div_clr;
  assign bus.freq_o    = freq;
  assign bus.ofst_o    = ofst;
  assign bus.step_o    = step_q;
  assign bus.busy_o    = (state_q != ST_IDLE);
  assign bus.done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - directed self-checking bench for nco_sweep_ctrl

module tb_nco_sweep_ctrl;

  localparam int NCYC = 40;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  nco_sweep_ctrl_if bus_if ();

  nco_sweep_ctrl #(
    .CLK_DIV      (4),
    .DEF_STEP     (16'd13107),
    .SETTLE_TICKS (2)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] tick_v, nrst_v, done_v, busy_v, freq_nz_v;
  logic [15:0] freq_a [NCYC];
  logic [15:0] ofst_a [NCYC];
  logic [15:0] step_a [NCYC];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] w16(input logic [15:0] x);
    return {48'd0, x};
  endfunction

  // bits lo..hi set
  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  // ticks every 4 cycles starting at 'first', up to 'last'
  function automatic logic [63:0] ticks(input int first, input int last);
    logic [63:0] v = '0;
    for (int i = first; i <= last; i += 4) v[i] = 1'b1;
    return v;
  endfunction

  // Cycle 0 is the cycle in which start_i is sampled; outputs of cycle c are
  // recorded at the falling edge inside it, then inputs for cycle c are driven.
  task automatic run(input logic [15:0] rate, input logic [15:0] nt, input logic [15:0] dw,
                     input logic [15:0] of, input int abort_cyc, input int start2_cyc,
                     input int rst_cyc);
    tick_v = '0; nrst_v = '0; done_v = '0; busy_v = '0; freq_nz_v = '0;
    @(negedge clk_i);
    bus_if.rate_i   = rate;
    bus_if.nticks_i = nt;
    bus_if.dwell_i  = dw;
    bus_if.ofst_i   = of;
    bus_if.start_i  = 1'b1;
    for (int c = 1; c < NCYC; c++) begin
      @(negedge clk_i);
      tick_v[c]    = bus_if.tick_o;
      nrst_v[c]    = bus_if.nco_rst_o;
      done_v[c]    = bus_if.done_o;
      busy_v[c]    = bus_if.busy_o;
      freq_nz_v[c] = (bus_if.freq_o != 16'sd0);
      freq_a[c]    = bus_if.freq_o;
      ofst_a[c]    = bus_if.ofst_o;
      step_a[c]    = bus_if.step_o;
      bus_if.start_i = (c == start2_cyc);
      if (c == start2_cyc) begin
        bus_if.rate_i   = 16'd99;
        bus_if.nticks_i = 16'd7;
        bus_if.dwell_i  = 16'd0;
        bus_if.ofst_i   = 16'd1234;
      end
      bus_if.abort_i = (c == abort_cyc);
      rst_i          = (c == rst_cyc);
    end
    bus_if.start_i = 1'b0;
    bus_if.abort_i = 1'b0;
    rst_i          = 1'b0;
  endtask

  initial begin
    bus_if.start_i  = 1'b0;
    bus_if.abort_i  = 1'b0;
    bus_if.rate_i   = '0;
    bus_if.nticks_i = '0;
    bus_if.dwell_i  = '0;
    bus_if.ofst_i   = '0;

    // reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_tick",  w16({15'd0, bus_if.tick_o}),    64'd0);
    check("rst_nrst",  w16({15'd0, bus_if.nco_rst_o}), 64'd0);
    check("rst_freq",  w16(bus_if.freq_o),             64'd0);
    check("rst_ofst",  w16(bus_if.ofst_o),             64'd0);
    check("rst_step",  w16(bus_if.step_o),             64'd13107);
    check("rst_busy",  w16({15'd0, bus_if.busy_o}),    64'd0);
    check("rst_done",  w16({15'd0, bus_if.done_o}),    64'd0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // basic run rate=10 nticks=3 dwell=2
    run(16'd10, 16'd3, 16'd2, 16'd0, -1, -1, -1);
    check("b_nrst",   nrst_v,               64'd1 << 1);
    check("b_ticks",  tick_v,               ticks(5, NCYC - 1));
    check("b_done",   done_v,               64'd1 << 30);
    check("b_busy",   busy_v,               span(1, 30));
    check("b_freq_nz", freq_nz_v,           span(10, 21));
    check("b_freq13", w16(freq_a[13]),      64'd10);
    check("b_freq21", w16(freq_a[21]),      64'd10);
    check("b_freq25", w16(freq_a[25]),      64'd0);
    check("b_step14", w16(step_a[14]),      64'd13117);
    check("b_step31", w16(step_a[31]),      64'd13137);

    // phase offset only on first sweep tick
    run(16'd1, 16'd2, 16'd1, 16'hFE0C, -1, -1, -1);
    check("o_ofst13", w16(ofst_a[13]),      64'hFE0C);
    check("o_ofst17", w16(ofst_a[17]),      64'd0);
    check("o_ofst9",  w16(ofst_a[9]),       64'd0);
    check("o_done",   done_v,               64'd1 << 22);
    check("o_step",   w16(step_a[23]),      64'd13109);

    // two's-complement wrap
    run(16'h8000, 16'd1, 16'd1, 16'd0, -1, -1, -1);
    check("w_step",   w16(step_a[19]),      64'd45875);
    check("w_done",   done_v,               64'd1 << 18);

    // zero sweep and dwell
    run(16'd10, 16'd0, 16'd0, 16'd0, -1, -1, -1);
    check("z_done",    done_v,              64'd1 << 10);
    check("z_freq_nz", freq_nz_v,           64'd0);
    check("z_step",    w16(step_a[12]),     64'd13107);

    // abort during sweep at cycle 15
    run(16'd10, 16'd3, 16'd2, 16'd0, 15, -1, -1);
    check("a_busy",   busy_v,               span(1, 15));
    check("a_done",   done_v,               64'd0);
    check("a_freq16", w16(freq_a[16]),      64'd0);
    check("a_step",   w16(step_a[20]),      64'd13117);

    // start during sweep is ignored
    run(16'd10, 16'd3, 16'd2, 16'd0, -1, 12, -1);
    check("s_done",   done_v,               64'd1 << 30);
    check("s_freq17", w16(freq_a[17]),      64'd10);
    check("s_step",   w16(step_a[31]),      64'd13137);

    // start and abort together in IDLE
    busy_v = '0;
    @(negedge clk_i);
    bus_if.start_i = 1'b1;
    bus_if.abort_i = 1'b1;
    for (int c = 1; c < 6; c++) begin
      @(negedge clk_i);
      busy_v[c] = bus_if.busy_o | bus_if.nco_rst_o;
      bus_if.start_i = 1'b0;
      bus_if.abort_i = 1'b0;
    end
    check("sa_busy", busy_v, 64'd0);

    // reset mid-dwell (cycle 26)
    run(16'd10, 16'd3, 16'd2, 16'd0, -1, -1, 26);
    check("r_step26", w16(step_a[26]),      64'd13137);
    check("r_step27", w16(step_a[27]),      64'd13107);
    check("r_busy",   busy_v,               span(1, 26));
    check("r_done",   done_v,               64'd0);
    check("r_ticks",  tick_v,               ticks(5, 25) | ticks(30, NCYC - 1));
    check("r_freq27", w16(freq_a[27]),      64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
- Sequencer for one NCO channel. Generates the NCO sample strobe and runs a programmed linear chirp: reset NCO, settle, ramp the step word, dwell, report done.
- Sits between the host/config interface and the NCO tick, reset, frequency-rate and phase-offset inputs.
- Keeps a mirror of the NCO step word so the host can read the current frequency without tapping the NCO.

Parameters:
- CLK_DIV, 250: clk_i cycles per sample tick (>=2).
- DEF_STEP, 13107: step value the NCO loads on reset (40 kHz); the mirror loads the same value.
- SETTLE_TICKS, 16: ticks waited after NCO reset before the ramp starts (>=1).

Ports:
- clk_i in 1: system clock.
- rst_i in 1: synchronous, active-high reset.
- start_i in 1: single-cycle request; sampled only in IDLE.
- abort_i in 1: cancel the running sequence.
- rate_i in 16 signed: per-tick step increment during SWEEP.
- nticks_i in 16 unsigned: number of SWEEP ticks.
- dwell_i in 16 unsigned: number of DWELL ticks.
- ofst_i in 16 signed: phase offset applied once, on the first SWEEP tick.
- tick_o out 1: NCO sample strobe.
- nco_rst_o out 1: NCO reset pulse.
- freq_o out 16 signed: drives NCO frequency-rate input.
- ofst_o out 16 signed: drives NCO phase-offset input.
- step_o out 16 unsigned: mirror of the NCO step word.
- busy_o out 1: high in any state except IDLE.
- done_o out 1: one-cycle completion pulse.

Behaviour:
- Reset values: state IDLE; divider count 0; tick_o 0; nco_rst_o 0; freq_o 0; ofst_o 0; step_o DEF_STEP; busy_o 0; done_o 0; latched config 0.
- Divider:
  - Count runs 0..CLK_DIV-1 and wraps.
  - tick_o is high for one cycle when count == CLK_DIV-1.
  - The count is forced to 0 in the NCO_RST cycle, so tick_o is never high in that cycle.
  - The divider free-runs in IDLE, so the NCO keeps ticking.
- States and transitions:
  - IDLE: on start_i & !abort_i, latch rate_i, nticks_i, dwell_i, ofst_i; go to NCO_RST.
  - NCO_RST: nco_rst_o = 1 for exactly this one cycle; go to SETTLE.
  - SETTLE: count ticks. On the SETTLE_TICKS-th tick, go to SWEEP. If nticks == 0, go to DWELL instead; if dwell is also 0, go to DONE.
  - SWEEP: freq_o = rate for every tick in this state, exactly nticks ticks. After the last tick, go to DWELL, or to DONE if dwell == 0.
  - DWELL: freq_o = 0; after dwell ticks, go to DONE.
  - DONE: done_o = 1 for one cycle; go to IDLE.
- Output timing:
  - freq_o and ofst_o are decoded from registered state and count, so they are stable whenever tick_o is high.
  - ofst_o = latched ofst only while in SWEEP with sweep count == 0; otherwise 0.
- Step mirror:
  - Loads DEF_STEP when nco_rst_o is high.
  - On tick_o, step_o <= step_o + freq_o, with 16-bit two's-complement wrap. No saturation.
- Abort: abort_i in any non-IDLE state forces IDLE next cycle. done_o stays 0, freq_o returns to 0, and step_o keeps its current value.
- Simultaneous events:
  - start_i is ignored while busy.
  - start_i and abort_i together in IDLE: abort wins, state stays IDLE.
  - rst_i overrides everything, including mid-sequence.
- Tick counters are 16 bits and compare against latched values, so input changes during a run have no effect.

Decomposition:
- Shared package nco_pkg holds:
  - the state enum sweep_state_t;
  - the constant NCO_DEF_STEP = 13107, also used by the NCO reset step so the two cannot drift apart;
  - the typedef nco_word_t = logic signed [15:0].
- One natural sub-module, tick_divider: the CLK_DIV counter with a synchronous clear input, outputting tick.

Test Plan (CLK_DIV=4, SETTLE_TICKS=2; start_i sampled at cycle 0):
- Basic run, rate=10, nticks=3, dwell=2:
  - nco_rst_o high at cycle 1.
  - tick_o at cycles 5, 9 (SETTLE), 13, 17, 21 (SWEEP, freq_o=10), 25, 29 (DWELL, freq_o=0).
  - done_o high only at cycle 30; step_o 13107 -> 13137.
- ofst=-500, rate=1, nticks=2, dwell=1: ofst_o = -500 only on the cycle-13 tick and 0 on the cycle-17 tick; step_o ends at 13109.
- Wrap, rate=-32768, nticks=1, dwell=1: step_o 13107 -> 45875, wrapping mod 2^16; done_o pulses.
- Zero counts, nticks=0, dwell=0: SETTLE goes directly to DONE; freq_o never nonzero; step_o = 13107; done_o at cycle 10.
- abort_i at cycle 15 during SWEEP: busy_o low from cycle 16; no done_o; freq_o 0; step_o = 13117 (rate=10, one sweep tick taken).
- Control edge cases:
  - start_i during SWEEP is ignored; config is unchanged.
  - start_i and abort_i together in IDLE: busy_o stays 0.
  - rst_i mid-DWELL: all outputs return to reset values the next cycle.
